alu_share_ctrl: RTL and testbench



---
 rtl/alu_share_pkg.sv | 24 ++
 rtl/alu_share_arb.sv | 45 ++++
 rtl/alu_share_ctrl.sv | 110 +++++++++++
 tb/tb_alu_share_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// alu_share_pkg: op codes, FSM state type and legal-op decode shared by the ALU sharing block.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package alu_share_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True for the five op codes the shared ALU implements.
    function automatic logic alu_op_legal(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
               (op == ALU_OR)  || (op == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_share_arb.sv
// alu_share_arb: 2-way grant for the shared ALU, fixed priority or round-robin tie-break.
// Latency: grant is combinational from the valids; pointer updates on the accepting edge.
// Backpressure: grants only while en is high (owner FSM idle); otherwise grant is 0.
// Build option: ALU_SHARE_RR_EN adds the last-grant pointer (clk/rst_n ports exist only then).
// Ports: en (FSM idle), req_valid[1:0], grant[1:0] one-hot or zero.
module alu_share_arb (
`ifdef ALU_SHARE_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic       en,
    input  logic [1:0] req_valid,
    output logic [1:0] grant
);

`ifdef ALU_SHARE_RR_EN
    // Id of the requester granted last; reset to 1 so requester 0 wins the first tie.
    logic last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (en && (req_valid != 2'b00)) begin
            last_grant <= grant[1];
        end
    end
`endif

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
`ifdef ALU_SHARE_RR_EN
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
`else
                2'b11:   grant = 2'b01;
`endif
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one single-cycle ALU between core (req0) and cache controller (req1).
// Latency: accept in T, ALU driven in T+1, response valid from T+2; next accept no earlier than T+3.
// Backpressure: owner rsp_ready low holds RESP and the response registers indefinitely; req ready 0 while busy.
// Build option: ALU_SHARE_RR_EN selects round-robin tie-break (default: requester 0 wins ties).
// Ports: clk/rst_n; req{0,1}_valid/ready/srcA/srcB/ctrl; rsp{0,1}_valid/ready, rsp_res/rsp_zero/rsp_illegal;
//        alu_srcA/alu_srcB/alu_ctrl drive the shared ALU, alu_res/alu_zero come back from it.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_srcA,
    input  logic [WIDTH-1:0] req0_srcB,
    input  logic [2:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_srcA,
    input  logic [WIDTH-1:0] req1_srcB,
    input  logic [2:0]       req1_ctrl,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_zero,
    output logic             rsp_illegal,
    output logic [WIDTH-1:0] alu_srcA,
    output logic [WIDTH-1:0] alu_srcB,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero
);

    state_t     state, state_nxt;
    logic [1:0] grant;
    logic       owner;
    logic       req_fire;
    logic       rsp_fire;

    alu_share_arb u_arb (
`ifdef ALU_SHARE_RR_EN
        .clk       (clk),
        .rst_n     (rst_n),
`endif
        .en        (state == ST_IDLE),
        .req_valid ({req1_valid, req0_valid}),
        .grant     (grant)
    );

    // Grant is already gated by IDLE, so ready depends only on the valids and state.
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign req_fire   = grant != 2'b00;

    assign rsp0_valid = (state == ST_RESP) && !owner;
    assign rsp1_valid = (state == ST_RESP) &&  owner;
    // Only the owner's ready can retire the response.
    assign rsp_fire   = owner ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_fire) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_fire) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue registers double as the ALU drive and keep the last op outside EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_srcA <= '0;
            alu_srcB <= '0;
            alu_ctrl <= 3'b000;
            owner    <= 1'b0;
        end else if ((state == ST_IDLE) && req_fire) begin
            alu_srcA <= grant[1] ? req1_srcA : req0_srcA;
            alu_srcB <= grant[1] ? req1_srcB : req0_srcB;
            alu_ctrl <= grant[1] ? req1_ctrl : req0_ctrl;
            owner    <= grant[1];
        end
    end

    // Response registers load once at the end of EXEC and then hold until the next op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_res     <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_res     <= alu_res;
            rsp_zero    <= alu_zero;
            rsp_illegal <= !alu_op_legal(alu_ctrl);
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_srcA = '0, req0_srcB = '0, req1_srcA = '0, req1_srcB = '0;
    logic [2:0]  req0_ctrl = '0, req1_ctrl = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp_res;
    logic        rsp_zero, rsp_illegal;
    logic [31:0] alu_srcA, alu_srcB;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_res;
    logic        alu_zero;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_srcA(req0_srcA), .req0_srcB(req0_srcB), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_srcA(req1_srcA), .req1_srcB(req1_srcB), .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_res(rsp_res), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl),
        .alu_res(alu_res), .alu_zero(alu_zero)
    );

    // ---------------- reference ALU (stands in for the shared instance) ----------------
    function automatic logic ref_legal(input logic [2:0] c);
        return c == 3'b000 || c == 3'b001 || c == 3'b010 || c == 3'b011 || c == 3'b101;
    endfunction

    function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_zero(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        return ref_legal(c) && (ref_res(a, b, c) == 32'd0);
    endfunction

    assign alu_res  = ref_res(alu_srcA, alu_srcB, alu_ctrl);
    assign alu_zero = ref_zero(alu_srcA, alu_srcB, alu_ctrl);

    // ---------------- transaction-level model ----------------
    // An op accepted at cycle k drives the ALU from k+1 and is answered from k+2
    // until its owner takes it; nothing is accepted while an op is outstanding.
    int          m_cyc, m_acc;
    logic        m_busy, m_owner, m_last;
    logic [31:0] m_a, m_b, m_res;
    logic [2:0]  m_c;
    logic        m_zero, m_ill;

    function automatic logic [1:0] exp_grant();
        if (m_busy) return 2'b00;
        if (req0_valid && !req1_valid) return 2'b01;
        if (req1_valid && !req0_valid) return 2'b10;
        if (req0_valid && req1_valid) begin
`ifdef ALU_SHARE_RR_EN
            return (m_last == 1'b1) ? 2'b01 : 2'b10;
`else
            return 2'b01;
`endif
        end
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= 0; m_acc <= 0; m_busy <= 1'b0; m_owner <= 1'b0; m_last <= 1'b1;
            m_a <= '0; m_b <= '0; m_c <= '0; m_res <= '0; m_zero <= 1'b0; m_ill <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (!m_busy) begin
                if (exp_grant() == 2'b01) begin
                    m_busy <= 1'b1; m_owner <= 1'b0; m_last <= 1'b0; m_acc <= m_cyc;
                    m_a <= req0_srcA; m_b <= req0_srcB; m_c <= req0_ctrl;
                end else if (exp_grant() == 2'b10) begin
                    m_busy <= 1'b1; m_owner <= 1'b1; m_last <= 1'b1; m_acc <= m_cyc;
                    m_a <= req1_srcA; m_b <= req1_srcB; m_c <= req1_ctrl;
                end
            end else if (m_cyc == m_acc + 1) begin
                m_res  <= ref_res(m_a, m_b, m_c);
                m_zero <= ref_zero(m_a, m_b, m_c);
                m_ill  <= !ref_legal(m_c);
            end else if (m_owner ? rsp1_ready : rsp0_ready) begin
                m_busy <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        logic [1:0] eg;
        logic       on;
        eg = exp_grant();
        on = m_busy && (m_cyc - m_acc >= 2);
        chkb("req0_ready", req0_ready, eg[0]);
        chkb("req1_ready", req1_ready, eg[1]);
        chkb("rsp0_valid", rsp0_valid, on && !m_owner);
        chkb("rsp1_valid", rsp1_valid, on && m_owner);
        chk("rsp_res", rsp_res, m_res);
        chkb("rsp_zero", rsp_zero, m_zero);
        chkb("rsp_illegal", rsp_illegal, m_ill);
        chk("alu_srcA", alu_srcA, m_a);
        chk("alu_srcB", alu_srcB, m_b);
        chk("alu_ctrl", {29'b0, alu_ctrl}, {29'b0, m_c});
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_all();
    endtask

    // Presents one op alone; returns in the EXEC cycle with valid dropped.
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        if (id == 0) begin
            req0_valid = 1'b1; req0_srcA = a; req0_srcB = b; req0_ctrl = c;
        end else begin
            req1_valid = 1'b1; req1_srcA = a; req1_srcB = b; req1_ctrl = c;
        end
        #1;
        chkb("issue_ready", (id == 0) ? req0_ready : req1_ready, 1'b1);
        tick();
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int id, input logic [31:0] er, input logic ez, input logic ei);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if ((id == 0) ? rsp0_valid : rsp1_valid) begin
                got = 1'b1;
                chk("lit_res", rsp_res, er);
                chkb("lit_zero", rsp_zero, ez);
                chkb("lit_illegal", rsp_illegal, ei);
                chkb("lit_other_valid", (id == 0) ? rsp1_valid : rsp0_valid, 1'b0);
            end
        end
        chkb("rsp_arrived", got, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid[$];
        int gat[$];

        // Reset and release: everything must read 0.
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chkb("lit_reset_rdy0", req0_ready, 1'b0);
        chk("lit_reset_res", rsp_res, 32'd0);
        chk("lit_reset_alu", alu_srcA, 32'd0);

        // ADD 5+7 from requester 0.
        issue(0, 32'd5, 32'd7, 3'b000);
        chk("lit_exec_srcA", alu_srcA, 32'd5);
        wait_rsp(0, 32'd12, 1'b0, 1'b0);
        tick(); tick();

        // SUB 9-9 from requester 1 sets the zero flag.
        issue(1, 32'd9, 32'd9, 3'b001);
        wait_rsp(1, 32'd0, 1'b1, 1'b0);
        tick(); tick();

        // Tie: both valid continuously with responses always accepted.
        req0_valid = 1'b1; req0_srcA = 32'd1; req0_srcB = 32'd2; req0_ctrl = 3'b000;
        req1_valid = 1'b1; req1_srcA = 32'hF0; req1_srcB = 32'h0F; req1_ctrl = 3'b011;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (req0_ready) begin gid.push_back(0); gat.push_back(i); end
            if (req1_ready) begin gid.push_back(1); gat.push_back(i); end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("lit_tie_count", gid.size(), 32'd4);
        for (int k = 0; k < 4 && k < gid.size(); k++) begin
`ifdef ALU_SHARE_RR_EN
            chk("lit_tie_id", gid[k], k % 2);
`else
            chk("lit_tie_id", gid[k], 32'd0);
`endif
            chk("lit_tie_cycle", gat[k], 3 * k);
        end
        tick(); tick(); tick();

        // Backpressure: SLT -3 < 2 held for 5 cycles while requester 1 waits.
        rsp0_ready = 1'b0;
        issue(0, -32'sd3, 32'd2, 3'b101);
        req1_valid = 1'b1; req1_srcA = 32'd1; req1_srcB = 32'd1; req1_ctrl = 3'b000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chkb("lit_bp_valid", rsp0_valid, 1'b1);
            chk("lit_bp_res", rsp_res, 32'd1);
            chkb("lit_bp_rdy0", req0_ready, 1'b0);
            chkb("lit_bp_rdy1", req1_ready, 1'b0);
        end
        rsp0_ready = 1'b1;
        tick();
        chkb("lit_bp_next_rdy1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        wait_rsp(1, 32'd2, 1'b0, 1'b0);
        tick(); tick();

        // Illegal op code 110.
        issue(0, 32'd4, 32'd4, 3'b110);
        wait_rsp(0, 32'd0, 1'b0, 1'b1);
        tick(); tick();

        // Reset while the op is in EXEC: dropped, then a fresh op completes.
        issue(0, 32'd1, 32'd2, 3'b000);
        rst_n = 1'b0;
        #1;
        chkb("lit_midrst_rsp0", rsp0_valid, 1'b0);
        chk("lit_midrst_alu", alu_srcA, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chkb("lit_dropped_rsp0", rsp0_valid, 1'b0);
        end
        issue(1, 32'd100, -32'sd1, 3'b000);
        wait_rsp(1, 32'd99, 1'b0, 1'b0);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
